// File: rtl/platform_field_if.sv
// platform_field_if: ball motion in, platform layout and score out.
interface platform_field_if;
  logic        start;
  logic [10:0] BallX;
  logic [10:0] BallY;
  logic [9:0]  BallVY;
  logic [39:0] PlatX;
  logic [39:0] PlatY;
  logic        land;
  logic [3:0]  scroll_dy;
  logic [15:0] score;
  logic        game_over;
  modport master(output start, BallX, BallY, BallVY,
                 input PlatX, PlatY, land, scroll_dy, score, game_over);
  modport slave(input start, BallX, BallY, BallVY,
                output PlatX, PlatY, land, scroll_dy, score, game_over);
endinterface

// File: rtl/platform_field.sv
// platform_field: landing detection, scrolling, platform respawn, score and game-over for the jumper game.
module platform_field #(
  parameter int PLAT_W      = 80,
  parameter int BALL_W      = 8,
  parameter int BALL_H      = 10,
  parameter int LAND_TOL    = 5,
  parameter int SCROLL_LINE = 200,
  parameter int SCROLL_STEP = 2,
  parameter int SCREEN_H    = 480
) (
  input  logic Reset,
  input  logic frame_clk,
  platform_field_if.slave pf
);
  typedef enum logic [1:0] {IDLE, PLAY, SCROLL, OVER} state_t;
  typedef logic [3:0][9:0] plat_t;
  localparam plat_t INIT_X = {10'd200, 10'd380, 10'd100, 10'd240};
  localparam plat_t INIT_Y = {10'd110, 10'd230, 10'd350, 10'd470};
  localparam logic [2:0] NONE = 3'b111;
  state_t state, state_n;
  plat_t plat_x, plat_y, plat_x_n, plat_y_n;
  logic [2:0] last_idx, last_n, win;
  logic [9:0] lfsr, remain, remain_n, respawn_x;
  logic [15:0] score, score_n;
  logic [3:0] scroll_dy, dy_n, hit;
  logic land, land_n, game_over, active, fall;
  logic [10:0] foot, mid;
  assign foot = pf.BallY + 11'(BALL_H);
  assign mid = pf.BallX + 11'(BALL_W / 2);
  assign respawn_x = {1'b0, lfsr[8:0]} > 10'(640 - PLAT_W) ? {1'b0, lfsr[8:0]} - 10'd256 : {1'b0, lfsr[8:0]};
  assign active = state == PLAY || state == SCROLL;
  assign fall = active && foot >= 11'(SCREEN_H - 1);
  for (genvar i = 0; i < 4; i++) begin : g_hit
    logic [10:0] x0, y0, lo;
    assign x0 = {1'b0, plat_x[i]};
    assign y0 = {1'b0, plat_y[i]};
    assign lo = y0 >= 11'(LAND_TOL) ? y0 - 11'(LAND_TOL) : '0;
    assign hit[i] = !pf.BallVY[9] && pf.BallVY != '0 && mid >= x0 && mid <= x0 + 11'(PLAT_W) &&
                    foot >= lo && foot < y0 + 11'(LAND_TOL);
  end
  always_comb begin
    win = NONE;
    for (int i = 3; i >= 0; i--) if (hit[i]) win = 3'(i);
  end
  // Landing is judged on pre-scroll positions; respawn then clears a stale last_idx.
  always_comb begin
    state_n = state;
    plat_x_n = plat_x;
    plat_y_n = plat_y;
    last_n = last_idx;
    score_n = score;
    remain_n = remain;
    land_n = 1'b0;
    dy_n = '0;
    if (state == IDLE && pf.start) state_n = PLAY;
    if (state == OVER && pf.start) begin
      state_n = PLAY;
      plat_x_n = INIT_X;
      plat_y_n = INIT_Y;
      score_n = '0;
      last_n = NONE;
    end
    if (fall) state_n = OVER;
    else if (active) begin
      if (win != NONE) begin
        land_n = 1'b1;
        if (win != last_idx) begin
          last_n = win;
          score_n = score + {15'd0, score != 16'hFFFF};
        end
      end
      if (state == PLAY && pf.BallY < 11'(SCROLL_LINE)) begin
        state_n = SCROLL;
        remain_n = 10'(11'(SCROLL_LINE) - pf.BallY);
      end
      if (state == SCROLL) begin
        dy_n = 4'(SCROLL_STEP);
        remain_n = remain - 10'(SCROLL_STEP);
        state_n = remain <= 10'(SCROLL_STEP) ? PLAY : SCROLL;
        for (int i = 0; i < 4; i++) begin
          plat_y_n[i] = plat_y[i] + 10'(SCROLL_STEP);
          if (plat_y_n[i] >= 10'(SCREEN_H)) begin
            plat_y_n[i] = plat_y_n[i] - 10'(SCREEN_H);
            plat_x_n[i] = respawn_x;
            if (last_n == 3'(i)) last_n = NONE;
          end
        end
      end
    end
  end
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      plat_x <= INIT_X;
      plat_y <= INIT_Y;
      last_idx <= NONE;
      score <= '0;
      remain <= '0;
      land <= 1'b0;
      scroll_dy <= '0;
      game_over <= 1'b0;
      lfsr <= 10'h2A5;
    end else begin
      state <= state_n;
      plat_x <= plat_x_n;
      plat_y <= plat_y_n;
      last_idx <= last_n;
      score <= score_n;
      remain <= remain_n;
      land <= land_n;
      scroll_dy <= dy_n;
      game_over <= state_n == OVER;
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
  assign pf.PlatX = plat_x;
  assign pf.PlatY = plat_y;
  assign pf.land = land;
  assign pf.scroll_dy = scroll_dy;
  assign pf.score = score;
  assign pf.game_over = game_over;
endmodule

// File: tb/tb_platform_field.sv
// tb_platform_field: directed scenarios plus randomized play against a frame-level game model.
module tb_platform_field;
  logic Reset = 1'b1;
  logic frame_clk = 1'b0;
  int tests = 0, fails = 0, edges = 0;
  localparam int M_IDLE = 0, M_PLAY = 1, M_SCROLL = 2, M_OVER = 3;
  int mx[4], my[4];
  int m_mode, m_score, m_last, m_remain, m_lfsr, m_land, m_dy, m_go;
  platform_field_if pf();
  platform_field dut (.Reset(Reset), .frame_clk(frame_clk), .pf(pf));
  always #5 frame_clk = ~frame_clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [39:0] pack(input int a[4]);
    logic [39:0] p;
    for (int i = 0; i < 4; i++) p[i*10 +: 10] = 10'(a[i]);
    return p;
  endfunction
  function automatic int lfsr_after(input int n);
    int v = 'h2A5;
    repeat (n) v = ((v << 1) & 1023) | (((v >> 9) ^ (v >> 6)) & 1);
    return v;
  endfunction
  task automatic model_layout();
    mx = '{240, 100, 380, 200};
    my = '{470, 350, 230, 110};
  endtask
  task automatic model_reset();
    model_layout();
    m_mode = M_IDLE; m_score = 0; m_last = -1; m_remain = 0;
    m_lfsr = 'h2A5; m_land = 0; m_dy = 0; m_go = 0;
  endtask
  task automatic model_step(input bit st, input int bx, input int by, input int vy);
    int foot, mid, win, nx;
    foot = by + 10; mid = bx + 4; win = -1;
    m_land = 0; m_dy = 0;
    if (m_mode == M_IDLE) begin
      if (st) m_mode = M_PLAY;
    end else if (m_mode == M_OVER) begin
      if (st) begin model_layout(); m_score = 0; m_last = -1; m_mode = M_PLAY; end
    end else if (foot >= 479) m_mode = M_OVER;
    else begin
      for (int i = 3; i >= 0; i--)
        if (vy > 0 && mid >= mx[i] && mid <= mx[i] + 80 &&
            foot >= ((my[i] >= 5) ? my[i] - 5 : 0) && foot < my[i] + 5) win = i;
      if (win >= 0) begin
        m_land = 1;
        if (win != m_last) begin m_last = win; if (m_score < 65535) m_score++; end
      end
      if (m_mode == M_PLAY) begin
        if (by < 200) begin m_mode = M_SCROLL; m_remain = 200 - by; end
      end else begin
        m_dy = 2;
        for (int i = 0; i < 4; i++) begin
          my[i] += 2;
          if (my[i] >= 480) begin
            my[i] -= 480;
            nx = m_lfsr % 512;
            mx[i] = nx > 560 ? nx - 256 : nx;
            if (m_last == i) m_last = -1;
          end
        end
        if (m_remain <= 2) m_mode = M_PLAY;
        m_remain -= 2;
      end
    end
    m_go = m_mode == M_OVER;
    m_lfsr = ((m_lfsr << 1) & 1023) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
  endtask
  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".PlatX"}, pf.PlatX, pack(mx));
    chk({tag, ".PlatY"}, pf.PlatY, pack(my));
    chk({tag, ".land"}, 40'(pf.land), 40'(m_land));
    chk({tag, ".scroll_dy"}, 40'(pf.scroll_dy), 40'(m_dy));
    chk({tag, ".score"}, 40'(pf.score), 40'(m_score));
    chk({tag, ".game_over"}, 40'(pf.game_over), 40'(m_go));
  endtask
  task automatic step(input bit st, input int bx, input int by, input int vy, input string tag);
    pf.start = st; pf.BallX = 11'(bx); pf.BallY = 11'(by); pf.BallVY = 10'(vy);
    @(posedge frame_clk);
    edges++;
    model_step(st, bx, by, vy);
    #1;
    check_all(tag);
  endtask
  initial begin
    logic [39:0] y_before;
    int r, i, bx, by, vy;
    pf.start = 0; pf.BallX = 0; pf.BallY = 11'd300; pf.BallVY = 0;
    model_reset();
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
    check_all("reset");
    chk("reset_platY", pf.PlatY, {10'd110, 10'd230, 10'd350, 10'd470});
    step(1, 0, 300, 0, "start");
    step(0, 276, 460, 2, "land1");
    chk("land1_pulse", 40'(pf.land), 40'd1);
    chk("land1_score", 40'(pf.score), 40'd1);
    step(0, 276, 460, 2, "land2");
    chk("land2_pulse", 40'(pf.land), 40'd1);
    chk("land2_score", 40'(pf.score), 40'd1);
    step(0, 276, 460, -3, "rising");
    chk("rising_land", 40'(pf.land), 40'd0);
    step(0, 276, 466, 2, "low_foot");
    chk("low_foot_land", 40'(pf.land), 40'd0);
    chk("low_foot_score", 40'(pf.score), 40'd1);
    y_before = pf.PlatY;
    step(0, 300, 190, 0, "scroll_enter");
    chk("scroll_enter_dy", 40'(pf.scroll_dy), 40'd0);
    for (int k = 0; k < 5; k++) begin
      step(0, 300, 300, 0, "scroll");
      chk("scroll_dy", 40'(pf.scroll_dy), 40'd2);
    end
    chk("scroll_p3", 40'(pf.PlatY[39:30]), 40'(y_before[39:30] + 10'd10));
    chk("scroll_p1", 40'(pf.PlatY[19:10]), 40'(y_before[19:10] + 10'd10));
    chk("respawn_y", 40'(pf.PlatY[9:0]), 40'd0);
    chk("respawn_x", 40'(pf.PlatX[9:0]), 40'(lfsr_after(edges - 1) % 512));
    step(0, 300, 300, 0, "scroll_done");
    chk("scroll_done_dy", 40'(pf.scroll_dy), 40'd0);
    step(0, 276, 470, 2, "fall");
    chk("fall_over", 40'(pf.game_over), 40'd1);
    chk("fall_land", 40'(pf.land), 40'd0);
    step(0, 276, 300, 2, "over_hold");
    step(1, 0, 300, 0, "restart");
    chk("restart_platY", pf.PlatY, {10'd110, 10'd230, 10'd350, 10'd470});
    chk("restart_score", 40'(pf.score), 40'd0);
    chk("restart_go", 40'(pf.game_over), 40'd0);
    step(0, 276, 460, 2, "replay_land");
    step(0, 300, 150, 0, "scroll2_enter");
    repeat (3) step(0, 300, 300, 0, "scroll2");
    Reset = 1'b1;
    #1;
    model_reset();
    edges = 0;
    check_all("async_reset");
    chk("async_reset_dy", 40'(pf.scroll_dy), 40'd0);
    @(negedge frame_clk);
    Reset = 1'b0;
    step(1, 0, 300, 0, "post_reset_start");
    step(0, 300, 190, 0, "post_reset_scroll");
    step(0, 300, 300, 0, "post_reset_step");
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      i = $urandom_range(0, 3);
      vy = int'($urandom_range(0, 10)) - 5;
      bx = int'($urandom_range(0, 639));
      if (r < 50) begin
        by = my[i] - 16 + int'($urandom_range(0, 12));
        bx = mx[i] - 8 + int'($urandom_range(0, 92));
      end else if (r < 75) by = int'($urandom_range(100, 199));
      else if (r < 78) by = int'($urandom_range(469, 479));
      else by = int'($urandom_range(200, 468));
      if (by < 0) by = 0;
      if (bx < 0) bx = 0;
      step($urandom_range(0, 9) == 0, bx, by, vy, "rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
